// File: rtl/axi_burst_expander_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_expander_pkg
// Description : Shared burst-type and FSM encodings plus request legality check
// Revision    : 1.0 - initial release
// ============================================================================
package axi_burst_expander_pkg;

    localparam logic [1:0] c_BURST_FIXED = 2'd0;
    localparam logic [1:0] c_BURST_INCR  = 2'd1;
    localparam logic [1:0] c_BURST_WRAP  = 2'd2;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    // Reserved burst type, non power-of-two WRAP length or oversize beat.
    function automatic logic f_req_illegal(
        input logic [1:0] burst,
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [2:0] max_size
    );
        logic w_wrap_len_ok;
        w_wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'd3) ||
               ((burst == c_BURST_WRAP) && !w_wrap_len_ok) ||
               (size > max_size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_expander_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_expander_if
// Description : Request channel and beat stream of the burst expander
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_burst_expander_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   axid;
    logic [ADDR_WIDTH-1:0] axaddr;
    logic [7:0]            axlen;
    logic [2:0]            axsize;
    logic [1:0]            axburst;
    logic                  axvalid;
    logic                  axready;

    logic [ID_WIDTH-1:0]   beatId;
    logic [ADDR_WIDTH-1:0] beatAddr;
    logic                  beatLast;
    logic                  beatValid;
    logic                  beatReady;

    modport master (
        output axid, axaddr, axlen, axsize, axburst, axvalid, beatReady,
        input  axready, beatId, beatAddr, beatLast, beatValid
    );

    modport slave (
        input  axid, axaddr, axlen, axsize, axburst, axvalid, beatReady,
        output axready, beatId, beatAddr, beatLast, beatValid
    );
endinterface
`default_nettype wire

// File: rtl/axi_beat_addr_calc.sv
`default_nettype none
// ============================================================================
// Module      : axi_beat_addr_calc
// Description : Combinational next-beat address for FIXED / INCR / WRAP bursts
// Revision    : 1.0 - initial release
// ============================================================================
module axi_beat_addr_calc
    import axi_burst_expander_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic [ADDR_WIDTH-1:0] addr,
    input  wire logic [2:0]            size,
    input  wire logic [7:0]            len,
    input  wire logic [1:0]            burst,
    output logic      [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_len_p1;
    logic [ADDR_WIDTH-1:0] w_wrap_bytes;
    logic [ADDR_WIDTH-1:0] w_lower;
    logic [ADDR_WIDTH-1:0] w_inc;
    logic [ADDR_WIDTH-1:0] w_incr_next;

    assign w_step       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
    assign w_len_p1     = ADDR_WIDTH'(len) + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign w_wrap_bytes = w_step * w_len_p1;
    assign w_lower      = addr & ~(w_wrap_bytes - {{(ADDR_WIDTH-1){1'b0}}, 1'b1});
    assign w_inc        = addr + w_step;
    // INCR realigns after an unaligned first beat.
    assign w_incr_next  = (addr & ~(w_step - {{(ADDR_WIDTH-1){1'b0}}, 1'b1})) + w_step;

    always_comb begin
        next_addr = w_incr_next;
        case (burst)
            c_BURST_FIXED: next_addr = addr;
            c_BURST_WRAP:  next_addr = (w_inc == (w_lower + w_wrap_bytes)) ? w_lower : w_inc;
            default:       next_addr = w_incr_next;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_burst_expander.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_expander
// Description : Expands AXI-style burst requests into a per-beat address stream
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_expander
    import axi_burst_expander_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int DATA_BYTES_LOG2 = 3
) (
    input  wire logic             aclk,
    input  wire logic             resetn,
    axi_burst_expander_if.slave   bus,
    output logic                  busy,
    output logic                  protocolError
);

    localparam logic [2:0] c_MAX_SIZE = 3'(DATA_BYTES_LOG2);

    logic                  r_pend_valid;
    logic [ID_WIDTH-1:0]   r_pend_id;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [7:0]            r_pend_len;
    logic [2:0]            r_pend_size;
    logic [1:0]            r_pend_burst;

    logic [0:0]            r_state;
    logic [ID_WIDTH-1:0]   r_cur_id;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [7:0]            r_cur_len;
    logic [2:0]            r_cur_size;
    logic [1:0]            r_cur_burst;
    logic [7:0]            r_cur_count;
    logic                  r_err;

    logic                  w_req_hs;
    logic                  w_req_illegal;
    logic                  w_beat_hs;
    logic                  w_at_last;
    logic                  w_last_hs;
    logic                  w_load;
    logic [ADDR_WIDTH-1:0] w_next_addr;

    assign w_req_hs      = bus.axvalid && !r_pend_valid;
    assign w_req_illegal = f_req_illegal(bus.axburst, bus.axlen, bus.axsize, c_MAX_SIZE);
    assign w_beat_hs     = (r_state == c_ST_BURST) && bus.beatReady;
    assign w_at_last     = (r_cur_count == r_cur_len);
    assign w_last_hs     = w_beat_hs && w_at_last;
    // Loading on the last-beat edge is what removes the bubble between bursts.
    assign w_load        = r_pend_valid && ((r_state == c_ST_IDLE) || w_last_hs);

    axi_beat_addr_calc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_calc (
        .addr      (r_cur_addr),
        .size      (r_cur_size),
        .len       (r_cur_len),
        .burst     (r_cur_burst),
        .next_addr (w_next_addr)
    );

    // Illegal requests are normalised here so the burst path only sees legal ones.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_pend_valid <= 1'b0;
            r_pend_id    <= '0;
            r_pend_addr  <= '0;
            r_pend_len   <= '0;
            r_pend_size  <= '0;
            r_pend_burst <= '0;
        end else if (w_req_hs) begin
            r_pend_valid <= 1'b1;
            r_pend_id    <= bus.axid;
            r_pend_addr  <= bus.axaddr;
            r_pend_len   <= bus.axlen;
            r_pend_size  <= (bus.axsize > c_MAX_SIZE) ? c_MAX_SIZE : bus.axsize;
            r_pend_burst <= w_req_illegal ? c_BURST_INCR : bus.axburst;
        end else if (w_load) begin
            r_pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_ST_IDLE;
            r_cur_id    <= '0;
            r_cur_addr  <= '0;
            r_cur_len   <= '0;
            r_cur_size  <= '0;
            r_cur_burst <= '0;
            r_cur_count <= '0;
        end else if (w_load) begin
            r_state     <= c_ST_BURST;
            r_cur_id    <= r_pend_id;
            r_cur_addr  <= r_pend_addr;
            r_cur_len   <= r_pend_len;
            r_cur_size  <= r_pend_size;
            r_cur_burst <= r_pend_burst;
            r_cur_count <= '0;
        end else if (w_last_hs) begin
            r_state     <= c_ST_IDLE;
        end else if (w_beat_hs) begin
            r_cur_addr  <= w_next_addr;
            r_cur_count <= r_cur_count + 8'd1;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (w_req_hs && w_req_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign bus.axready    = !r_pend_valid;
    assign bus.beatValid  = (r_state == c_ST_BURST);
    assign bus.beatLast   = (r_state == c_ST_BURST) && w_at_last;
    assign bus.beatAddr   = r_cur_addr;
    assign bus.beatId     = r_cur_id;
    assign busy           = r_pend_valid || (r_state == c_ST_BURST);
    assign protocolError  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_expander.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_expander
// Description : Directed self-checking bench for axi_burst_expander
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_expander;
    import axi_burst_expander_pkg::*;

    localparam int c_AW = 32;
    localparam int c_IW = 8;

    logic aclk = 1'b0;
    logic resetn = 1'b0;
    logic busy;
    logic protocolError;

    int n_checks = 0;
    int n_fail   = 0;

    logic [c_AW-1:0] exp_addr [8];
    logic [c_IW-1:0] exp_id   [8];
    logic            exp_last [8];

    axi_burst_expander_if #(.ADDR_WIDTH(c_AW), .ID_WIDTH(c_IW)) bus ();

    axi_burst_expander #(
        .ADDR_WIDTH      (c_AW),
        .ID_WIDTH        (c_IW),
        .DATA_BYTES_LOG2 (3)
    ) u_dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .bus           (bus),
        .busy          (busy),
        .protocolError (protocolError)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset;
        resetn        = 1'b0;
        bus.axvalid   = 1'b0;
        bus.beatReady = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic set_beat(input int i, input logic [c_AW-1:0] a, input logic [c_IW-1:0] id, input logic l);
        exp_addr[i] = a;
        exp_id[i]   = id;
        exp_last[i] = l;
    endtask

    // Returns at #1 after the acceptance edge.
    task automatic send_req(input logic [c_IW-1:0] id, input logic [c_AW-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic accepted;
        accepted    = 1'b0;
        bus.axid    = id;
        bus.axaddr  = addr;
        bus.axlen   = len;
        bus.axsize  = size;
        bus.axburst = burst;
        bus.axvalid = 1'b1;
        for (int i = 0; i < 32 && !accepted; i++) begin
            if (bus.axready) accepted = 1'b1;
            tick();
        end
        bus.axvalid = 1'b0;
        check_eq("req_accepted", 64'(accepted), 64'd1);
    endtask

    // Starts on the cycle the first beat must be visible; stall cycles recheck held values.
    task automatic run_beats(input int n, input bit toggle);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 64) begin
            bus.beatReady = toggle ? (cyc % 2 == 0) : 1'b1;
            check_eq($sformatf("beat%0d_valid", k), 64'(bus.beatValid), 64'd1);
            check_eq($sformatf("beat%0d_addr", k), 64'(bus.beatAddr), 64'(exp_addr[k]));
            check_eq($sformatf("beat%0d_id", k), 64'(bus.beatId), 64'(exp_id[k]));
            check_eq($sformatf("beat%0d_last", k), 64'(bus.beatLast), 64'(exp_last[k]));
            if (bus.beatReady && bus.beatValid) k++;
            tick();
            cyc++;
        end
        check_eq("beats_done", 64'(k), 64'(n));
        bus.beatReady = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.axid = '0; bus.axaddr = '0; bus.axlen = '0; bus.axsize = '0;
        bus.axburst = '0; bus.axvalid = 1'b0; bus.beatReady = 1'b0;
        resetn = 1'b0;
        #3;
        check_eq("rst_axready", 64'(bus.axready), 64'd1);
        check_eq("rst_beatValid", 64'(bus.beatValid), 64'd0);
        check_eq("rst_beatLast", 64'(bus.beatLast), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_protocolError", 64'(protocolError), 64'd0);
        check_eq("rst_beatAddr", 64'(bus.beatAddr), 64'd0);
        check_eq("rst_beatId", 64'(bus.beatId), 64'd0);
        do_reset();

        // INCR aligned, first beat one cycle after acceptance
        bus.beatReady = 1'b1;
        send_req(8'h11, 32'h1000, 8'd3, 3'd3, c_BURST_INCR);
        check_eq("incr_no_beat_at_accept", 64'(bus.beatValid), 64'd0);
        check_eq("incr_busy_pending", 64'(busy), 64'd1);
        check_eq("incr_axready_pending", 64'(bus.axready), 64'd0);
        tick();
        set_beat(0, 32'h1000, 8'h11, 1'b0);
        set_beat(1, 32'h1008, 8'h11, 1'b0);
        set_beat(2, 32'h1010, 8'h11, 1'b0);
        set_beat(3, 32'h1018, 8'h11, 1'b1);
        run_beats(4, 1'b0);
        check_eq("incr_idle_valid", 64'(bus.beatValid), 64'd0);
        check_eq("incr_idle_busy", 64'(busy), 64'd0);
        check_eq("incr_idle_axready", 64'(bus.axready), 64'd1);

        // WRAP legal
        send_req(8'h22, 32'h1034, 8'd3, 3'd2, c_BURST_WRAP);
        tick();
        set_beat(0, 32'h1034, 8'h22, 1'b0);
        set_beat(1, 32'h1038, 8'h22, 1'b0);
        set_beat(2, 32'h103C, 8'h22, 1'b0);
        set_beat(3, 32'h1030, 8'h22, 1'b1);
        run_beats(4, 1'b0);
        check_eq("wrap_no_error", 64'(protocolError), 64'd0);

        // INCR unaligned with stalls
        send_req(8'h33, 32'h1003, 8'd2, 3'd2, c_BURST_INCR);
        tick();
        set_beat(0, 32'h1003, 8'h33, 1'b0);
        set_beat(1, 32'h1004, 8'h33, 1'b0);
        set_beat(2, 32'h1008, 8'h33, 1'b1);
        run_beats(3, 1'b1);

        // Back-to-back: no gap, axready low only while a request is pending
        set_beat(0, 32'h2000, 8'h01, 1'b0);
        set_beat(1, 32'h2004, 8'h01, 1'b1);
        set_beat(2, 32'h3000, 8'h02, 1'b0);
        set_beat(3, 32'h3008, 8'h02, 1'b1);
        fork
            begin
                send_req(8'h01, 32'h2000, 8'd1, 3'd2, c_BURST_INCR);
                send_req(8'h02, 32'h3000, 8'd1, 3'd3, c_BURST_INCR);
            end
            begin
                tick();
                check_eq("b2b_no_beat_at_accept", 64'(bus.beatValid), 64'd0);
                tick();
                run_beats(4, 1'b0);
            end
            begin
                tick();
                check_eq("b2b_axready_e0", 64'(bus.axready), 64'd0);
                tick();
                check_eq("b2b_axready_e1", 64'(bus.axready), 64'd1);
                tick();
                check_eq("b2b_axready_e2", 64'(bus.axready), 64'd0);
                tick();
                check_eq("b2b_axready_e3", 64'(bus.axready), 64'd1);
            end
        join
        check_eq("b2b_idle_busy", 64'(busy), 64'd0);

        // Request accepted on the same edge as the last beat, pending empty
        send_req(8'h0A, 32'h8000, 8'd0, 3'd2, c_BURST_INCR);
        tick();
        check_eq("sim_beat_valid", 64'(bus.beatValid), 64'd1);
        check_eq("sim_beat_last", 64'(bus.beatLast), 64'd1);
        check_eq("sim_beat_addr", 64'(bus.beatAddr), 64'h8000);
        send_req(8'h0B, 32'h9000, 8'd0, 3'd2, c_BURST_INCR);
        check_eq("sim_gap_valid", 64'(bus.beatValid), 64'd0);
        check_eq("sim_gap_busy", 64'(busy), 64'd1);
        tick();
        check_eq("sim_second_valid", 64'(bus.beatValid), 64'd1);
        check_eq("sim_second_addr", 64'(bus.beatAddr), 64'h9000);
        check_eq("sim_second_id", 64'(bus.beatId), 64'h0B);
        tick();
        check_eq("sim_done_valid", 64'(bus.beatValid), 64'd0);

        // WRAP with len 2 is illegal: flag and INCR expansion
        send_req(8'h44, 32'h5002, 8'd2, 3'd1, c_BURST_WRAP);
        check_eq("wraplen_error_at_accept", 64'(protocolError), 64'd1);
        tick();
        set_beat(0, 32'h5002, 8'h44, 1'b0);
        set_beat(1, 32'h5004, 8'h44, 1'b0);
        set_beat(2, 32'h5006, 8'h44, 1'b1);
        run_beats(3, 1'b0);
        check_eq("wraplen_error_held", 64'(protocolError), 64'd1);

        // Reserved burst type, then flag persists across a legal burst
        do_reset();
        check_eq("err_cleared_by_reset", 64'(protocolError), 64'd0);
        bus.beatReady = 1'b1;
        send_req(8'h55, 32'h4000, 8'd1, 3'd2, 2'd3);
        check_eq("burst3_error_at_accept", 64'(protocolError), 64'd1);
        tick();
        set_beat(0, 32'h4000, 8'h55, 1'b0);
        set_beat(1, 32'h4004, 8'h55, 1'b1);
        run_beats(2, 1'b0);
        send_req(8'h56, 32'h4100, 8'd0, 3'd2, c_BURST_FIXED);
        tick();
        set_beat(0, 32'h4100, 8'h56, 1'b1);
        run_beats(1, 1'b0);
        check_eq("burst3_error_persists", 64'(protocolError), 64'd1);

        // Oversize axsize clamps to the bus width
        do_reset();
        bus.beatReady = 1'b1;
        send_req(8'h66, 32'h6000, 8'd1, 3'd5, c_BURST_INCR);
        check_eq("size_error_at_accept", 64'(protocolError), 64'd1);
        tick();
        set_beat(0, 32'h6000, 8'h66, 1'b0);
        set_beat(1, 32'h6008, 8'h66, 1'b1);
        run_beats(2, 1'b0);

        // FIXED burst keeps the start address
        do_reset();
        bus.beatReady = 1'b1;
        send_req(8'h77, 32'h6A04, 8'd2, 3'd2, c_BURST_FIXED);
        tick();
        set_beat(0, 32'h6A04, 8'h77, 1'b0);
        set_beat(1, 32'h6A04, 8'h77, 1'b0);
        set_beat(2, 32'h6A04, 8'h77, 1'b1);
        run_beats(3, 1'b0);

        // Asynchronous reset mid-burst with a request pending
        send_req(8'h09, 32'h7000, 8'd7, 3'd2, c_BURST_INCR);
        send_req(8'h0C, 32'h7800, 8'd3, 3'd2, c_BURST_INCR);
        check_eq("mid_beat1_addr", 64'(bus.beatAddr), 64'h7004);
        tick();
        check_eq("mid_beat2_addr", 64'(bus.beatAddr), 64'h7008);
        check_eq("mid_pending_axready", 64'(bus.axready), 64'd0);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_beatValid", 64'(bus.beatValid), 64'd0);
        check_eq("mid_rst_axready", 64'(bus.axready), 64'd1);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_beatAddr", 64'(bus.beatAddr), 64'd0);
        repeat (2) tick();
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.beatValid) seen++;
        end
        check_eq("post_rst_no_beats", 64'(seen), 64'd0);
        check_eq("post_rst_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
